uart_rx_frame: RTL and testbench

Parametrised UART receiver, successor to the fixed-format receiver. It oversamples the serial line with majority-vote bit decisions. Frame format is selectable at run time: data bits, parity and one or two stop bits. Each received word is delivered with per-word parity and framing error flags over a valid/ready handshake. It sits between the pad-side RX line and the system register file or bus side, in the receive clock domain.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_fifo.sv | 57 +++++
 rtl/uart_rx_frame.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// Optional output FIFO is enabled in uart_rx_frame by defining UART_RX_FIFO_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int unsigned MIN_DATA_BITS = 5;
  // data_bits is 4 bits wide, so no frame ever carries more than 15 data bits.
  localparam int unsigned MAX_DATA_WIDTH = 16;

  typedef struct packed {
    logic [MAX_DATA_WIDTH-1:0] data;
    logic                      parity_error;
    logic                      framing_error;
  } rx_word_t;

  // Clamp a requested data-bit count into MIN_DATA_BITS..max_bits.
  function automatic logic [3:0] clamp_data_bits(logic [3:0] req, int unsigned max_bits);
    if (32'(req) < MIN_DATA_BITS) return 4'(MIN_DATA_BITS);
    if (32'(req) > max_bits) return 4'(max_bits);
    return req;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received words. Depth must be a power of two (>= 2).
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddrW:0] FullCnt = Depth[AddrW:0];

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AddrW:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  // Storage and pointers; storage clears on reset so the head reads 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= wdata_i;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver with run-time frame format and valid/ready output.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO; otherwise a single
// holding register buffers the received word. DATA_WIDTH must be 5..16.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [3:0]                data_bits,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  input  logic                      stop_bits,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      parity_error,
  output logic                      framing_error,
  output logic                      overrun,
  output logic                      busy
);

  localparam int unsigned EntryW = DATA_WIDTH + 2;
  localparam logic [PRESCALE_WIDTH-1:0] One = 1;

  logic [1:0] sync_q;
  logic       rx_s;

  rx_state_e                 state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] edge_q, edge_d, pre_q, pre_d, mid;
  logic [3:0]                bit_q, bit_d, nbits_q, nbits_d;
  logic [1:0]                samp_q, samp_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      perr_q, perr_d, ferr_q, ferr_d;
  logic                      par_en_q, par_en_d, par_type_q, par_type_d, stop2_q, stop2_d;
  logic                      at_s0, at_s1, at_dec, at_end, maj, stop_last;

  rx_word_t          word;
  logic [EntryW-1:0] entry, buf_head;
  logic              push, pop, buf_valid, buf_full, overrun_q, overrun_d;
  logic              unused_word;

  // Two-flop synchronizer; flops reset high so reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (RST) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], RX_IN};
  end
  assign rx_s = sync_q[1];

  assign mid       = pre_q >> 1;
  assign at_s0     = (edge_q == mid - One);
  assign at_s1     = (edge_q == mid);
  assign at_dec    = (edge_q == mid + One);
  assign at_end    = (edge_q == pre_q - One);
  assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign stop_last = !stop2_q || (bit_q == 4'd1);

  // FSM next-state: sampling, bit assembly, parity/stop checks and completion push.
  always_comb begin
    state_d    = state_q;
    edge_d     = at_end ? '0 : edge_q + One;
    bit_d      = bit_q;
    samp_d     = samp_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    pre_d      = pre_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    stop2_d    = stop2_q;
    push       = 1'b0;
    if (at_s0) samp_d[0] = rx_s;
    if (at_s1) samp_d[1] = rx_s;
    unique case (state_q)
      StIdle: begin
        edge_d = '0;
        if (!rx_s) begin
          // The detection cycle is count 0 of the start bit, so START begins at 1.
          state_d    = StStart;
          edge_d     = One;
          bit_d      = '0;
          data_d     = '0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          pre_d      = Prescale;
          nbits_d    = clamp_data_bits(data_bits, DATA_WIDTH);
          par_en_d   = parity_enable;
          par_type_d = parity_type;
          stop2_d    = stop_bits;
        end
      end
      StStart: begin
        if (at_dec && maj) state_d = StIdle;
        else if (at_end)   state_d = StData;
      end
      StData: begin
        if (at_dec) data_d = data_q | (DATA_WIDTH'(maj) << bit_q);
        if (at_end) begin
          if (bit_q == nbits_q - 4'd1) begin
            bit_d   = '0;
            state_d = par_en_q ? StParity : StStop;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (at_dec) perr_d = (maj != ((^data_q) ^ (par_type_q != PARITY_EVEN)));
        if (at_end) state_d = StStop;
      end
      StStop: begin
        if (at_dec && !maj) ferr_d = 1'b1;
        // Complete at the last stop decision so a start edge half a bit later is caught.
        if (at_dec && stop_last) begin
          push    = 1'b1;
          state_d = StIdle;
        end else if (at_end) begin
          bit_d = bit_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and latched frame-format registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      edge_q     <= '0;
      bit_q      <= '0;
      samp_q     <= '0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      pre_q      <= '0;
      nbits_q    <= 4'(MIN_DATA_BITS);
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      samp_q     <= samp_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      pre_q      <= pre_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      stop2_q    <= stop2_d;
    end
  end

  // Word assembled at completion; the final stop decision folds in combinationally.
  always_comb begin
    word.data          = MAX_DATA_WIDTH'(data_q);
    word.parity_error  = perr_q;
    word.framing_error = ferr_q | ~maj;
  end
  assign entry       = {word.data[DATA_WIDTH-1:0], word.parity_error, word.framing_error};
  assign unused_word = ^word.data;

`ifdef UART_RX_FIFO_EN
  logic fifo_full, fifo_empty;

  uart_rx_fifo #(
    .Width(EntryW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_i  (RST),
    .push_i (push),
    .wdata_i(entry),
    .pop_i  (pop),
    .rdata_o(buf_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign buf_valid = !fifo_empty;
  assign buf_full  = fifo_full;
`else
  logic [EntryW-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic              unused_depth;

  assign unused_depth = ^FIFO_DEPTH;

  // Single-entry holding register; a push on full is taken only alongside a pop.
  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (push && (!hold_vld_q || pop)) begin
      hold_d     = entry;
      hold_vld_d = 1'b1;
    end else if (pop) begin
      hold_vld_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  assign buf_head  = hold_q;
  assign buf_valid = hold_vld_q;
  assign buf_full  = hold_vld_q;
`endif

  assign pop       = buf_valid && data_ready;
  assign overrun_d = push && buf_full && !pop;

  // Overrun pulse lands in the cycle the dropped word would have presented.
  always_ff @(posedge CLK) begin
    if (RST) overrun_q <= 1'b0;
    else     overrun_q <= overrun_d;
  end

  assign {P_DATA, parity_error, framing_error} = buf_head;
  assign data_valid = buf_valid;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame. Expected words are decoded from the
// generated line waveform; buffering is modelled as a capacity limit.
module tb_uart_rx_frame;

  localparam int DW = 8;
`ifdef UART_RX_FIFO_EN
  localparam int Cap = 4;
`else
  localparam int Cap = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic [3:0] data_bits = 4'd8;
  logic       parity_enable = 1'b0;
  logic       parity_type = 1'b0;
  logic       stop_bits = 1'b0;
  logic       data_ready = 1'b1;
  logic [DW-1:0] P_DATA;
  logic       data_valid, parity_error, framing_error, overrun, busy;

  int n_run = 0;
  int n_fail = 0;
  int ovr_cnt = 0;
  logic [DW+1:0] got_q[$];
  logic [DW+1:0] exp_q[$];

  always #5 CLK = ~CLK;

  uart_rx_frame #(
    .DATA_WIDTH(DW),
    .PRESCALE_WIDTH(6),
    .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .RX_IN(RX_IN),
    .Prescale(Prescale),
    .data_bits(data_bits),
    .parity_enable(parity_enable),
    .parity_type(parity_type),
    .stop_bits(stop_bits),
    .P_DATA(P_DATA),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .parity_error(parity_error),
    .framing_error(framing_error),
    .overrun(overrun),
    .busy(busy)
  );

  // Collect accepted words and overrun pulses once per cycle, mid-cycle.
  always @(negedge CLK) begin
    #1;
    if (!RST && data_valid && data_ready) got_q.push_back({P_DATA, parity_error, framing_error});
    if (!RST && overrun) ovr_cnt++;
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Drive one frame and queue the word a correct receiver must report for it.
  task automatic send_frame(input int pre, input logic [7:0] d, input int nb_req, input bit pen,
                            input bit ptype, input bit two_stop, input bit bad_par,
                            input bit bad_stop);
    int eff;
    bit bits[$];
    logic [7:0] m, dec;
    bit perr, ferr;
    eff = (nb_req < 5) ? 5 : ((nb_req > DW) ? DW : nb_req);
    m = 8'((1 << eff) - 1);
    bits.push_back(1'b0);
    for (int i = 0; i < eff; i++) bits.push_back(d[i]);
    if (pen) bits.push_back((^(d & m)) ^ ptype ^ bad_par);
    bits.push_back(!bad_stop);
    if (two_stop) bits.push_back(1'b1);
    dec = '0;
    for (int i = 0; i < eff; i++) dec[i] = bits[1+i];
    perr = pen && (bits[1+eff] != ((^dec) ^ ptype));
    ferr = 1'b0;
    for (int i = 1 + eff + (pen ? 1 : 0); i < bits.size(); i++) if (!bits[i]) ferr = 1'b1;
    exp_q.push_back({dec, perr, ferr});
    Prescale = 6'(pre);
    data_bits = 4'(nb_req);
    parity_enable = pen;
    parity_type = ptype;
    stop_bits = two_stop;
    foreach (bits[i]) begin
      RX_IN = bits[i];
      repeat (pre) @(negedge CLK);
    end
    RX_IN = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_run++; if (P_DATA !== '0) begin n_fail++; $display("FAIL reset_pdata: got %h want 0", P_DATA); end
    n_run++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    n_run++; if (parity_error !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", parity_error); end
    n_run++; if (framing_error !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", framing_error); end
    n_run++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    RST = 1'b0;
    idle(5);
    got_q.delete(); exp_q.delete(); ovr_cnt = 0;
  endtask

  task automatic test_basic();
    send_frame(8, 8'hA5, 8, 1, 0, 0, 0, 0);
    idle(30);
    n_run++; if (got_q.size() != 1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", got_q.size()); end
    else begin
      n_run++; if (got_q[0] !== {8'hA5, 2'b00}) begin n_fail++; $display("FAIL basic_word: got %h want %h", got_q[0], {8'hA5, 2'b00}); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_errors();
    send_frame(8, 8'hA5, 8, 1, 0, 0, 1, 0);
    idle(24);
    send_frame(8, 8'h3E, 8, 1, 0, 0, 0, 1);
    idle(40);
    n_run++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL errors_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_run++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL errors_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    send_frame(16, 8'h3C, 7, 1, 1, 1, 0, 0);
    send_frame(16, 8'h41, 7, 1, 1, 1, 0, 0);
    idle(60);
    n_run++; if (got_q.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", got_q.size()); end
    else foreach (exp_q[i]) begin
      n_run++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    bit saw, cleared;
    int busy_cycles;
    saw = 0; cleared = 0; busy_cycles = 0;
    Prescale = 6'd8;
    idle(5);
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RX_IN = 1'b1;
    for (int i = 0; i < 40 && !cleared; i++) begin
      @(negedge CLK);
      if (busy) begin saw = 1; busy_cycles++; end
      else if (saw) cleared = 1;
    end
    n_run++; if (!saw) begin n_fail++; $display("FAIL glitch_busy_seen: got 0 want 1"); end
    n_run++; if (!cleared) begin n_fail++; $display("FAIL glitch_busy_timeout: busy still %b want 0", busy); end
    n_run++; if (busy_cycles > 8) begin n_fail++; $display("FAIL glitch_busy_len: got %0d want <=8", busy_cycles); end
    idle(10);
    n_run++; if (got_q.size() != 0) begin n_fail++; $display("FAIL glitch_no_word: got %0d want 0", got_q.size()); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    ovr_cnt = 0;
    data_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_frame(8, 8'(k), 8, 1, 0, 0, 0, 0);
    idle(30);
    n_run++; if (ovr_cnt != 5 - Cap) begin n_fail++; $display("FAIL ovf_overruns: got %0d want %0d", ovr_cnt, 5 - Cap); end
    for (int i = 0; i < 4; i++) begin
      n_run++;
      if (data_valid !== 1'b1 || {P_DATA, parity_error, framing_error} !== exp_q[0]) begin
        n_fail++; $display("FAIL ovf_hold%0d: got v=%b %h want v=1 %h", i, data_valid,
                           {P_DATA, parity_error, framing_error}, exp_q[0]);
      end
      @(negedge CLK);
    end
    data_ready = 1'b1;
    idle(10);
    n_run++; if (got_q.size() != Cap) begin n_fail++; $display("FAIL ovf_drain_count: got %0d want %0d", got_q.size(), Cap); end
    else for (int i = 0; i < Cap; i++) begin
      n_run++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_drain%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_run++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", data_valid); end
    got_q.delete(); exp_q.delete(); ovr_cnt = 0;
  endtask

  task automatic test_reset_mid();
    Prescale = 6'd8; data_bits = 4'd8; parity_enable = 1'b1; parity_type = 1'b0; stop_bits = 1'b0;
    RX_IN = 1'b0; repeat (8) @(negedge CLK);
    RX_IN = 1'b1; repeat (8) @(negedge CLK);
    RX_IN = 1'b0; repeat (8) @(negedge CLK);
    RX_IN = 1'b1; repeat (4) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    idle(20);
    send_frame(8, 8'h5A, 8, 1, 0, 0, 0, 0);
    idle(30);
    n_run++; if (got_q.size() != 1) begin n_fail++; $display("FAIL rstmid_count: got %0d want 1", got_q.size()); end
    else begin
      n_run++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL rstmid_word: got %h want %h", got_q[0], exp_q[0]); end
    end
    n_run++; if (ovr_cnt != 0) begin n_fail++; $display("FAIL rstmid_overrun: got %0d want 0", ovr_cnt); end
    got_q.delete(); exp_q.delete(); ovr_cnt = 0;
  endtask

  task automatic test_random();
    int pre, nb;
    bit pen, pt, two, bp, bs;
    for (int f = 0; f < 24; f++) begin
      pre = $urandom_range(4, 40);
      nb  = $urandom_range(3, 12);
      pen = 1'($urandom); pt = 1'($urandom); two = 1'($urandom);
      bp  = ($urandom_range(0, 3) == 0);
      bs  = ($urandom_range(0, 3) == 0);
      send_frame(pre, 8'($urandom), nb, pen, pt, two, bp, bs);
      if (bs) idle(2 * pre + 2);
      else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, pre));
    end
    idle(120);
    n_run++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_run++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_run++; if (ovr_cnt != 0) begin n_fail++; $display("FAIL rand_overrun: got %0d want 0", ovr_cnt); end
    got_q.delete(); exp_q.delete(); ovr_cnt = 0;
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_basic();
    test_errors();
    test_back_to_back();
    test_glitch();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
